// File: rtl/core_irq_pkg.sv
// core_irq_pkg: shared constants and state encoding for the interrupt scheduler
package core_irq_pkg;
  localparam int ID_W = 3;
  localparam int MAX_IRQ = 8;
  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_CLEAR = 2'd1;
  localparam logic [1:0] ADDR_EOI = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
endpackage

// File: rtl/core_irq_prio_enc.sv
// core_irq_prio_enc: lowest-index-wins priority encoder
module core_irq_prio_enc
  import core_irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    i_req,
  output logic [ID_W-1:0] o_id,
  output logic            o_any
);
  always_comb begin
    o_id = '0;
    for (int i = N - 1; i >= 0; i--) o_id = i_req[i] ? ID_W'(i) : o_id;
  end
  assign o_any = |i_req;
endmodule

// File: rtl/core_irq_sched.sv
// core_irq_sched: edge/level interrupt latching with single-request ack/EOI handshake
module core_irq_sched
  import core_irq_pkg::*;
#(
  parameter int                 N_IRQ      = 8,
  parameter logic [MAX_IRQ-1:0] LEVEL_MASK = 8'h00
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_wr,
  input  logic [1:0]       i_wr_addr,
  input  logic [7:0]       i_wr_data,
  output logic             o_irq,
  input  logic             i_irq_ack,
  output logic [7:0]       o_id,
  output logic [N_IRQ-1:0] o_pending
);
  state_t r_state, w_next;
  logic [N_IRQ-1:0] r_prev, r_pend, r_mask, w_set, w_clr, w_ack_clr, w_cand;
  logic [MAX_IRQ-1:0] w_cand8;
  logic [ID_W-1:0] r_id, w_win;
  logic [7:0] r_id_out;
  logic r_irq, w_any, w_wr_mask, w_wr_clr, w_eoi, w_ack;
  core_irq_prio_enc #(.N(N_IRQ)) u_enc (.i_req(w_cand), .o_id(w_win), .o_any(w_any));
  assign w_set = (i_irq & ~r_prev) | (i_irq & LEVEL_MASK[N_IRQ-1:0]);
  assign w_cand = r_pend & r_mask;
  assign w_cand8 = MAX_IRQ'(w_cand);
  assign w_wr_mask = i_wr && i_wr_addr == ADDR_MASK;
  assign w_wr_clr = i_wr && i_wr_addr == ADDR_CLEAR;
  assign w_eoi = i_wr && i_wr_addr == ADDR_EOI;
  assign w_clr = w_wr_clr ? i_wr_data[N_IRQ-1:0] : '0;
  // withdrawal beats a same-cycle ack, so ack only counts while the source is still a candidate
  assign w_ack = r_state == REQ && i_irq_ack && w_cand8[r_id];
  assign w_ack_clr = (w_ack && !LEVEL_MASK[r_id]) ? N_IRQ'(MAX_IRQ'(1) << r_id) : '0;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_any ? REQ : IDLE;
      REQ:     w_next = !w_cand8[r_id] ? IDLE : (i_irq_ack ? SVC : REQ);
      SVC:     w_next = w_eoi ? IDLE : SVC;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_prev   <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_id     <= '0;
      r_irq    <= 1'b0;
      r_id_out <= '0;
    end else begin
      r_state  <= w_next;
      r_prev   <= i_irq;
      r_pend   <= (r_pend & ~w_clr & ~w_ack_clr) | w_set;
      r_mask   <= w_wr_mask ? i_wr_data[N_IRQ-1:0] : r_mask;
      r_id     <= (r_state == IDLE && w_any) ? w_win : r_id;
      r_irq    <= w_next == REQ;
      r_id_out <= (w_next == SVC) ? {1'b1, 4'b0, r_id} : '0;
    end
  end
  assign o_irq = r_irq;
  assign o_id = r_id_out;
  assign o_pending = r_pend;
endmodule

// File: tb/tb_core_irq_sched.sv
// tb_core_irq_sched: vector table, directed corner sequences and randomized model comparison
module tb_core_irq_sched;
  logic clk = 1'b0, rst, wr, ack, o_irq;
  logic [7:0] irq, data, o_id, o_pending;
  logic [1:0] addr;
  int checks = 0, errors = 0;

  bit [7:0] m_pend, m_mask, m_prev;
  int m_mode, m_id;

  typedef struct {
    logic rst; logic [7:0] irq; logic wr; logic [1:0] addr; logic [7:0] data; logic ack;
    logic e_irq; logic [7:0] e_id; logic [7:0] e_pend;
  } vec_t;
  vec_t tbl[14];

  core_irq_sched #(.N_IRQ(8), .LEVEL_MASK(8'h00)) dut (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_wr(wr), .i_wr_addr(addr), .i_wr_data(data),
    .o_irq(o_irq), .i_irq_ack(ack), .o_id(o_id), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // mode 0 = waiting for events, 1 = requesting, 2 = in service
  task automatic model_update();
    bit [7:0] cand, setb, clrb, ackb;
    int win;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_mode = 0; m_id = 0;
      return;
    end
    cand = m_pend & m_mask;
    setb = irq & ~m_prev;
    clrb = (wr && addr == 2'd1) ? data : 8'h00;
    ackb = 0;
    win = -1;
    for (int k = 7; k >= 0; k--) if (cand[k]) win = k;
    if (m_mode == 0) begin
      if (win >= 0) begin m_mode = 1; m_id = win; end
    end else if (m_mode == 1) begin
      if (!cand[m_id]) m_mode = 0;
      else if (ack) begin m_mode = 2; ackb[m_id] = 1'b1; end
    end else if (wr && addr == 2'd2) m_mode = 0;
    m_pend = (m_pend & ~clrb & ~ackb) | setb;
    if (wr && addr == 2'd0) m_mask = data;
    m_prev = irq;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    chk("model_irq", {7'b0, o_irq}, {7'b0, m_mode == 1});
    chk("model_id", o_id, m_mode == 2 ? 8'h80 | 8'(m_id) : 8'h00);
    chk("model_pending", o_pending, m_pend);
  endtask

  task automatic step(input logic [7:0] i, input logic w, input logic [1:0] a,
                      input logic [7:0] d, input logic k);
    rst = 1'b0; irq = i; wr = w; addr = a; data = d; ack = k;
    cycle();
  endtask

  task automatic wait_irq(input string n);
    for (int k = 0; k < 6 && !o_irq; k++) step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    chk(n, {7'b0, o_irq}, 8'h01);
  endtask

  initial begin
    rst = 1'b1; irq = 8'hFF; wr = 1'b0; addr = 2'd0; data = 8'h00; ack = 1'b0;
    for (int i = 0; i < 5; i++)
      tbl[i] = '{1'b1, 8'hFF, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 8'hFF, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 2'd1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 2'd0, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{1'b0, 8'h04, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h04};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h04};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h82, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h82, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; irq = tbl[i].irq; wr = tbl[i].wr; addr = tbl[i].addr;
      data = tbl[i].data; ack = tbl[i].ack;
      cycle();
      chk($sformatf("vec%0d_irq", i), {7'b0, o_irq}, {7'b0, tbl[i].e_irq});
      chk($sformatf("vec%0d_id", i), o_id, tbl[i].e_id);
      chk($sformatf("vec%0d_pending", i), o_pending, tbl[i].e_pend);
    end

    // priority between two simultaneous edges
    step(8'h00, 1'b1, 2'd0, 8'hFF, 1'b0);
    step(8'h22, 1'b0, 2'd0, 8'h00, 1'b0);
    wait_irq("prio_req1");
    step(8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("prio_id1", o_id, 8'h81);
    step(8'h00, 1'b1, 2'd2, 8'h00, 1'b0);
    wait_irq("prio_req2");
    step(8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("prio_id2", o_id, 8'h85);
    step(8'h00, 1'b1, 2'd2, 8'h00, 1'b0);

    // withdrawal by CLEAR before ack
    step(8'h00, 1'b1, 2'd0, 8'h08, 1'b0);
    step(8'h08, 1'b0, 2'd0, 8'h00, 1'b0);
    wait_irq("wd_req");
    step(8'h00, 1'b1, 2'd1, 8'h08, 1'b0);
    step(8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("wd_irq", {7'b0, o_irq}, 8'h00);
    step(8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("wd_ack_ignored", o_id, 8'h00);

    // set wins over same-cycle clear
    step(8'h00, 1'b1, 2'd0, 8'h00, 1'b0);
    step(8'h01, 1'b1, 2'd1, 8'h01, 1'b0);
    chk("set_vs_clr", {7'b0, o_pending[0]}, 8'h01);

    // reset during service, then fresh service without EOI
    step(8'h00, 1'b1, 2'd0, 8'h01, 1'b0);
    wait_irq("rst_req");
    step(8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("rst_svc", o_id, 8'h80);
    rst = 1'b1; irq = 8'h00; wr = 1'b0; ack = 1'b0;
    cycle();
    chk("rst_id", o_id, 8'h00);
    chk("rst_pending", o_pending, 8'h00);
    step(8'h00, 1'b1, 2'd0, 8'h02, 1'b0);
    step(8'h02, 1'b0, 2'd0, 8'h00, 1'b0);
    wait_irq("rst_req2");
    step(8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("rst_id2", o_id, 8'h81);

    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      irq = 8'($urandom) & 8'($urandom) & 8'($urandom);
      wr = ($urandom_range(0, 3) == 0);
      addr = 2'($urandom);
      data = 8'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
